fetch_decode_unit: RTL and testbench
====================================

# fetch_decode_unit

Single-cycle fetch/decode block: the 10-bit program counter, a 16-entry branch-target lookup table, and the combinational instruction decoder for the 9-bit accumulator-style ISA. It sits between the instruction ROM and the datapath (register file, ALU, data memory, memory/ALU LUTs). It drives every datapath control and mux output for the current instruction.

## Interface
- D, 10: program-counter width.
- PC_TABLE, {16{10'h0}} overridden by default to entry i = 64*i: 16×10-bit branch targets; entry i occupies bits [10i+9:10i].
- clk  in  1  rising-edge clock.
- reset  in  1  active-low reset, asynchronous to clk.
- mach_code  in  9  current instruction from instruction ROM.
- datA, datB  in  8  register-file read data for regA/regB.
- mem_out  in  8  data-memory read data.
- mem_lut_out  in  8  memory-LUT output, indexed by immed.
- alu_rslt  in  8  ALU result.
- prog_ctr  out  D  current PC.
- regA, regB, wr_addr  out  4  register read/write addresses.
- RegWrite, MemWrite, MemtoReg, ALUSrc, Branch  out  1  control strobes.
- ALUOp  out  4  ALU command.
- dat_in  out  8  register write data.
- mem_in, mem_addr  out  8  memory write data and address.
- immed  out  5  mach_code[4:0], always.
- pc_immed  out  4  mach_code[3:0], always.

## Operation
- Fields: op = mach_code[8:5], s = mach_code[4], r = mach_code[3:0]. Register r0 is the accumulator.
- Defaults for all opcodes: regA=0, regB=r, wr_addr=0, all strobes 0, ALUOp=0, dat_in=alu_rslt, mem_in=datA, mem_addr=0.
- op 0000–0111 ALU reg: ALUOp=op, RegWrite=1. s=0 writes r0; s=1 writes register r.
- 1000 ADDI: ALUSrc=1, ALUOp=0000, RegWrite=1. Computes r0 <= r0 + aluLUT[immed].
- 1001 LDL: mem_addr=mem_lut_out, dat_in=mem_out, MemtoReg=1, RegWrite=1.
- 1010 LDR: mem_addr=datB, dat_in=mem_out, MemtoReg=1, RegWrite=1.
- 1011 STL: mem_addr=mem_lut_out, MemWrite=1.
- 1100 STR: mem_addr=datB, MemWrite=1.
- 1101 MOV: s=0 computes r0 <= r (dat_in=datB). s=1 computes r <= r0 (wr_addr=r, dat_in=datA). RegWrite=1.
- 1110 BZ/BNZ: Branch = (s==0) ? (datA==0) : (datA!=0).
- 1111 JMP/HALT: s=0 gives Branch=1. s=1 is HALT (see Configuration).
- PC_LUT: target = PC_TABLE[pc_immed]. Purely combinational.
- Decoder is purely combinational. It has no state.

## Timing
- PC: while reset is low, prog_ctr=0, asynchronously.
- On each rising clk edge with reset high, the PC updates in priority order:
  1. Halt active: hold.
  2. Branch=1: load target.
  3. Otherwise: increment.
- Increment wraps 1023 -> 0.
- Branch redirect takes effect on the edge ending the branch cycle. There are no delay slots.
- All decode outputs settle within the same cycle as mach_code and the data inputs. Latency is 0 cycles.
- MemWrite and RegWrite are consumed by downstream clocked storage on the next edge.
- Reset deasserting mid-cycle: the first increment occurs at the first rising edge after release.
- Every decode output is a function of its inputs only. Reset does not affect the decoder.

## Configuration
- FETCH_HALT_EN defined: op 1111 with s=1 freezes prog_ctr and forces Branch=0. The PC stays frozen until reset.
- FETCH_HALT_EN undefined: op 1111 with s=1 is a NOP (all strobes 0) and the PC increments.

## Test plan
- Reset and increment: hold reset low, then release and apply instr 000000001 for 3 edges -> prog_ctr 0, 1, 2, 3.
- Taken and not-taken branch: instr 111000101 (BZ, r=5).
  - datA=0 -> Branch=1; next prog_ctr=320.
  - datA=7 -> Branch=0; next prog_ctr=PC+1.
- Load via LUT: instr 100100101, mem_lut_out=0x40, mem_out=0xAB -> mem_addr=0x40, dat_in=0xAB, wr_addr=0, RegWrite=1, MemtoReg=1, MemWrite=0.
- Indirect store: instr 110000011, datA=0x5A, datB=0x10 -> regB=3, MemWrite=1, mem_addr=0x10, mem_in=0x5A, RegWrite=0.
- Wrap: PC=1023 with instr 000000000 -> next prog_ctr=0.
- HALT: instr 111110000.
  - With FETCH_HALT_EN: prog_ctr constant over 5 edges.
  - Without FETCH_HALT_EN: increments by 5.

Source files
------------

// File: rtl/fetch_decode_unit.sv
// Fetch/decode: 10-bit PC, 16-entry branch-target table, accumulator-ISA decoder.
// Optional macro FETCH_HALT_EN: op 1111 with s=1 freezes the PC until reset.
module fetch_decode_unit #(
    parameter int D = 10,
    parameter logic [16*D-1:0] PC_TABLE = {
        10'd960, 10'd896, 10'd832, 10'd768,
        10'd704, 10'd640, 10'd576, 10'd512,
        10'd448, 10'd384, 10'd320, 10'd256,
        10'd192, 10'd128, 10'd64,  10'd0
    }
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [8:0]   mach_code,
    input  logic [7:0]   datA,
    input  logic [7:0]   datB,
    input  logic [7:0]   mem_out,
    input  logic [7:0]   mem_lut_out,
    input  logic [7:0]   alu_rslt,
    output logic [D-1:0] prog_ctr,
    output logic [3:0]   regA,
    output logic [3:0]   regB,
    output logic [3:0]   wr_addr,
    output logic         RegWrite,
    output logic         MemWrite,
    output logic         MemtoReg,
    output logic         ALUSrc,
    output logic         Branch,
    output logic [3:0]   ALUOp,
    output logic [7:0]   dat_in,
    output logic [7:0]   mem_in,
    output logic [7:0]   mem_addr,
    output logic [4:0]   immed,
    output logic [3:0]   pc_immed
);

    logic [3:0]   op;
    logic         s;
    logic [3:0]   r;
    logic [D-1:0] target;
    logic [D-1:0] pc_q, pc_d;
    logic         halt_active;

    assign op       = mach_code[8:5];
    assign s        = mach_code[4];
    assign r        = mach_code[3:0];
    assign immed    = mach_code[4:0];
    assign pc_immed = mach_code[3:0];
    assign target   = PC_TABLE[pc_immed*D +: D];
    assign prog_ctr = pc_q;

    always_comb begin
        regA     = 4'd0;
        regB     = r;
        wr_addr  = 4'd0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        Branch   = 1'b0;
        ALUOp    = 4'd0;
        dat_in   = alu_rslt;
        mem_in   = datA;
        mem_addr = 8'd0;
        if (!op[3]) begin
            ALUOp    = op;
            RegWrite = 1'b1;
            if (s) wr_addr = r;
        end else begin
            case (op[2:0])
                3'b000: begin
                    ALUSrc   = 1'b1;
                    RegWrite = 1'b1;
                end
                3'b001: begin
                    mem_addr = mem_lut_out;
                    dat_in   = mem_out;
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                3'b010: begin
                    mem_addr = datB;
                    dat_in   = mem_out;
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                3'b011: begin
                    mem_addr = mem_lut_out;
                    MemWrite = 1'b1;
                end
                3'b100: begin
                    mem_addr = datB;
                    MemWrite = 1'b1;
                end
                3'b101: begin
                    RegWrite = 1'b1;
                    if (s) begin
                        wr_addr = r;
                        dat_in  = datA;
                    end else begin
                        dat_in  = datB;
                    end
                end
                3'b110: Branch = s ? (datA != 8'd0) : (datA == 8'd0);
                default: Branch = ~s;
            endcase
        end
    end

`ifdef FETCH_HALT_EN
    // Once a HALT is seen the PC stays frozen until reset.
    logic halted_q, halted_d;

    always_comb begin
        halted_d    = halted_q | ((op == 4'hF) & s);
        halt_active = halted_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) halted_q <= 1'b0;
        else        halted_q <= halted_d;
    end
`else
    assign halt_active = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q + D'(1);
        if (halt_active)  pc_d = pc_q;
        else if (Branch)  pc_d = target;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pc_q <= '0;
        else        pc_q <= pc_d;
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench for fetch_decode_unit: random and directed instructions
// checked against a spec-level model of PC flow and decode.
module tb_fetch_decode_unit;

    typedef struct packed {
        logic [3:0] regA;
        logic [3:0] regB;
        logic [3:0] wr;
        logic       rw;
        logic       mw;
        logic       m2r;
        logic       asrc;
        logic       br;
        logic [3:0] aluop;
        logic [7:0] dat_in;
        logic [7:0] mem_in;
        logic [7:0] mem_addr;
        logic [4:0] immed;
        logic [3:0] pc_immed;
    } dec_t;

    typedef struct packed {
        logic [9:0] pc;
        dec_t       dec;
    } item_t;

    logic       clk;
    logic       reset;
    logic [8:0] mach_code;
    logic [7:0] datA, datB, mem_out, mem_lut_out, alu_rslt;
    logic [9:0] prog_ctr;
    logic [3:0] regA, regB, wr_addr, ALUOp;
    logic       RegWrite, MemWrite, MemtoReg, ALUSrc, Branch;
    logic [7:0] dat_in, mem_in, mem_addr;
    logic [4:0] immed;
    logic [3:0] pc_immed;

    item_t q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    mpc = 0;
    bit    mhalt = 0;

    fetch_decode_unit dut (
        .clk(clk), .reset(reset), .mach_code(mach_code),
        .datA(datA), .datB(datB), .mem_out(mem_out),
        .mem_lut_out(mem_lut_out), .alu_rslt(alu_rslt),
        .prog_ctr(prog_ctr), .regA(regA), .regB(regB),
        .wr_addr(wr_addr), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .Branch(Branch),
        .ALUOp(ALUOp), .dat_in(dat_in), .mem_in(mem_in),
        .mem_addr(mem_addr), .immed(immed), .pc_immed(pc_immed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic dec_t model(input logic [8:0] ins, input logic [7:0] a,
                                   input logic [7:0] b, input logic [7:0] mo,
                                   input logic [7:0] ml, input logic [7:0] ar);
        dec_t e;
        int op, s, r;
        op = int'(ins[8:5]);
        s  = int'(ins[4]);
        r  = int'(ins[3:0]);
        e = '0;
        e.regB     = 4'(r);
        e.dat_in   = ar;
        e.mem_in   = a;
        e.immed    = ins[4:0];
        e.pc_immed = ins[3:0];
        if (op <= 7) begin
            e.aluop = 4'(op);
            e.rw    = 1;
            e.wr    = (s == 1) ? 4'(r) : 4'd0;
        end else if (op == 8) begin
            e.asrc = 1; e.rw = 1;
        end else if (op == 9 || op == 10) begin
            e.mem_addr = (op == 9) ? ml : b;
            e.dat_in   = mo;
            e.m2r = 1; e.rw = 1;
        end else if (op == 11 || op == 12) begin
            e.mem_addr = (op == 11) ? ml : b;
            e.mw = 1;
        end else if (op == 13) begin
            e.rw = 1;
            if (s == 1) begin
                e.wr = 4'(r); e.dat_in = a;
            end else begin
                e.dat_in = b;
            end
        end else if (op == 14) begin
            e.br = (s == 0) ? (a == 0) : (a != 0);
        end else begin
            e.br = (s == 0);
        end
        return e;
    endfunction

    // Drive one instruction for one cycle; expectation goes to the scoreboard.
    task automatic apply(input logic [8:0] ins, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] mo,
                         input logic [7:0] ml, input logic [7:0] ar);
        item_t it;
        bit is_halt;
        mach_code = ins; datA = a; datB = b;
        mem_out = mo; mem_lut_out = ml; alu_rslt = ar;
        it.pc  = 10'(mpc);
        it.dec = model(ins, a, b, mo, ml, ar);
        q.push_back(it);
        is_halt = (ins[8:4] == 5'b11111);
        @(posedge clk);
        #1;
        if (!reset) begin
            mpc = 0; mhalt = 0;
        end else begin
`ifdef FETCH_HALT_EN
            if (is_halt) mhalt = 1;
`endif
            if (mhalt)            mpc = mpc;
            else if (it.dec.br)   mpc = 64 * int'(ins[3:0]);
            else                  mpc = (mpc + 1) % 1024;
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            dec_t act;
            it = q.pop_front();
            act = '{regA, regB, wr_addr, RegWrite, MemWrite, MemtoReg,
                    ALUSrc, Branch, ALUOp, dat_in, mem_in, mem_addr,
                    immed, pc_immed};
            check("pc", 64'(prog_ctr), 64'(it.pc));
            check("decode", 64'(act), 64'(it.dec));
        end
    end

    initial begin
        logic [8:0] ins;
        logic [7:0] a;
        int pc0;
        reset = 1'b0;
        mach_code = '0; datA = '0; datB = '0;
        mem_out = '0; mem_lut_out = '0; alu_rslt = '0;
        #2;
        check("reset_pc", 64'(prog_ctr), 64'd0);
        @(posedge clk); #1;
        apply(9'h001, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        apply(9'h001, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55);
        reset = 1'b1;
        for (int i = 0; i < 3; i++)
            apply(9'h001, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
        check("pc_after_3", 64'(prog_ctr), 64'd3);

        apply(9'b111000101, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("bz_taken", 64'(prog_ctr), 64'd320);
        apply(9'b111000101, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00);
        check("bz_not_taken", 64'(prog_ctr), 64'd321);
        apply(9'b100100101, 8'h00, 8'h00, 8'hAB, 8'h40, 8'h77);
        apply(9'b110000011, 8'h5A, 8'h10, 8'h00, 8'h00, 8'h00);

        apply(9'h1EF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("jmp_960", 64'(prog_ctr), 64'd960);
        for (int i = 0; i < 63; i++)
            apply(9'h000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("pc_1023", 64'(prog_ctr), 64'd1023);
        apply(9'h000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        check("pc_wrap", 64'(prog_ctr), 64'd0);

        for (int i = 0; i < 300; i++) begin
            ins = 9'($urandom);
`ifdef FETCH_HALT_EN
            if (ins[8:4] == 5'b11111) ins[4] = 1'b0;
`endif
            a = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            apply(ins, a, 8'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom));
        end

        pc0 = int'(prog_ctr);
        for (int i = 0; i < 5; i++)
            apply(9'b111110000, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
`ifdef FETCH_HALT_EN
        check("halt_hold", 64'(prog_ctr), 64'(pc0));
`else
        check("halt_nop", 64'(prog_ctr), 64'((pc0 + 5) % 1024));
`endif

        @(negedge clk); #1;
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
